// File: rtl/alarm_siren_driver.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : alarm_siren_driver
//  Description : Drives the physical siren from the alarm controller's level
//                output. Produces a timed on/off beep pattern and limits each
//                alarm event to MAX_BEEPS beeps. After the last beep it stays
//                silent (LOCKOUT) until the alarm level drops.
//  Ports       : clk        - system clock, rising edge
//                rst        - synchronous reset, active-low
//                alarm      - alarm level, high = intrusion active
//                siren      - siren drive, high = sounding
//                active     - high while beeping (on or off phase)
//                timed_out  - high while locked out (beep budget used up)
//                beep_count - beeps started in the current event
//  Revision    : 1.0 - initial release
// ============================================================================
module alarm_siren_driver #(
  parameter int ON_CYCLES  = 3,
  parameter int OFF_CYCLES = 2,
  parameter int MAX_BEEPS  = 4,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alarm,
  output logic       siren,
  output logic       active,
  output logic       timed_out,
  output logic [7:0] beep_count
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BEEP_ON = 2'd1;
  localparam logic [1:0] S_BEEP_OFF= 2'd2;
  localparam logic [1:0] S_LOCKOUT = 2'd3;

  localparam logic [CNT_W-1:0] C_ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_OFF_LAST = CNT_W'(OFF_CYCLES - 1);
  localparam logic [7:0]       C_MAX      = 8'(MAX_BEEPS);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_beep_count;
  logic             r_siren;
  logic             r_active;
  logic             r_timed_out;

  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [7:0]       w_beep_count_nxt;

  // Next-state logic. An alarm clear is checked first in every beeping
  // state so it wins over a phase end on the same edge.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_beep_count_nxt = r_beep_count;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt        = '0;
        w_beep_count_nxt = 8'd0;
        if (alarm) begin
          w_state_nxt      = S_BEEP_ON;
          w_beep_count_nxt = 8'd1;
        end
      end
      S_BEEP_ON: begin
        if (!alarm) begin
          w_state_nxt      = S_IDLE;
          w_cnt_nxt        = '0;
          w_beep_count_nxt = 8'd0;
        end else if (r_cnt == C_ON_LAST) begin
          w_cnt_nxt = '0;
          // The final beep ends straight into lockout with no off phase.
          if (r_beep_count == C_MAX) begin
            w_state_nxt = S_LOCKOUT;
          end else begin
            w_state_nxt = S_BEEP_OFF;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_BEEP_OFF: begin
        if (!alarm) begin
          w_state_nxt      = S_IDLE;
          w_cnt_nxt        = '0;
          w_beep_count_nxt = 8'd0;
        end else if (r_cnt == C_OFF_LAST) begin
          w_state_nxt      = S_BEEP_ON;
          w_cnt_nxt        = '0;
          w_beep_count_nxt = r_beep_count + 8'd1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_LOCKOUT: begin
        w_cnt_nxt = '0;
        if (!alarm) begin
          w_state_nxt      = S_IDLE;
          w_beep_count_nxt = 8'd0;
        end
      end
      default: begin
        w_state_nxt      = S_IDLE;
        w_cnt_nxt        = '0;
        w_beep_count_nxt = 8'd0;
      end
    endcase
  end

  // Output flops are loaded from the next state so they change on the same
  // edge as the state register and stay glitch-free.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_beep_count <= 8'd0;
      r_siren      <= 1'b0;
      r_active     <= 1'b0;
      r_timed_out  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_beep_count <= w_beep_count_nxt;
      r_siren      <= (w_state_nxt == S_BEEP_ON);
      r_active     <= (w_state_nxt == S_BEEP_ON) || (w_state_nxt == S_BEEP_OFF);
      r_timed_out  <= (w_state_nxt == S_LOCKOUT);
    end
  end

  assign siren      = r_siren;
  assign active     = r_active;
  assign timed_out  = r_timed_out;
  assign beep_count = r_beep_count;

endmodule
`default_nettype wire

// File: tb/tb_alarm_siren_driver.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : tb_alarm_siren_driver
//  Description : Scoreboard bench for alarm_siren_driver. Two instances: one
//                with default timing (3 on / 2 off / 4 beeps) and one with
//                the minimum settings (1 on / 1 off / 1 beep). Stimulus is
//                applied on the falling edge together with the hand-computed
//                outputs expected after the next rising edge; a monitor
//                compares them just after that rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_siren_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b0, alarm_a = 1'b0;
  logic       siren_a, active_a, timed_out_a;
  logic [7:0] beep_count_a;

  logic       rst_b = 1'b0, alarm_b = 1'b0;
  logic       siren_b, active_b, timed_out_b;
  logic [7:0] beep_count_b;

  alarm_siren_driver #(.ON_CYCLES(3), .OFF_CYCLES(2), .MAX_BEEPS(4), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst_a), .alarm(alarm_a),
    .siren(siren_a), .active(active_a), .timed_out(timed_out_a), .beep_count(beep_count_a)
  );

  alarm_siren_driver #(.ON_CYCLES(1), .OFF_CYCLES(1), .MAX_BEEPS(1), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst(rst_b), .alarm(alarm_b),
    .siren(siren_b), .active(active_b), .timed_out(timed_out_b), .beep_count(beep_count_b)
  );

  typedef struct {
    logic       sel;
    logic       s;
    logic       a;
    logic       t;
    logic [7:0] bc;
    string      name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // One full default event, one entry per cycle after the starting edge:
  // 111 00 111 00 111 00 111 with beep counts 1..4.
  logic [0:17] s_pat;
  logic [7:0]  bc_tab [18];

  task automatic step(input logic sel, input logic r, input logic al,
                      input logic es, input logic ea, input logic et,
                      input logic [7:0] eb, input string nm);
    exp_t e;
    @(negedge clk);
    if (sel == 1'b0) begin
      rst_a = r; alarm_a = al;
    end else begin
      rst_b = r; alarm_b = al;
    end
    e.sel = sel; e.s = es; e.a = ea; e.t = et; e.bc = eb; e.name = nm;
    q.push_back(e);
  endtask

  task automatic ev_step(input int i, input string nm);
    step(1'b0, 1'b1, 1'b1, s_pat[i], 1'b1, 1'b0, bc_tab[i], nm);
  endtask

  // Monitor: every output cycle that has an expectation queued is compared.
  initial begin
    exp_t       e;
    logic       as, aa, at;
    logic [7:0] ab;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.sel == 1'b0) begin
          as = siren_a; aa = active_a; at = timed_out_a; ab = beep_count_a;
        end else begin
          as = siren_b; aa = active_b; at = timed_out_b; ab = beep_count_b;
        end
        n_cmp++;
        if (as !== e.s || aa !== e.a || at !== e.t || ab !== e.bc) begin
          n_bad++;
          $display("FAIL %s @%0t: got siren=%b active=%b timed_out=%b beep_count=%0d, expected siren=%b active=%b timed_out=%b beep_count=%0d",
                   e.name, $time, as, aa, at, ab, e.s, e.a, e.t, e.bc);
        end
      end
    end
  end

  initial begin
    s_pat  = 18'b111_00_111_00_111_00_111;
    bc_tab = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1,
               8'd2, 8'd2, 8'd2, 8'd2, 8'd2,
               8'd3, 8'd3, 8'd3, 8'd3, 8'd3,
               8'd4, 8'd4, 8'd4};

    // Reset held with alarm high: everything stays zero.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "reset_hold");

    // Release reset with alarm high, then a full event with 40 alarm-high cycles.
    for (int i = 0; i < 18; i++) ev_step(i, "full_event");
    for (int i = 0; i < 22; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd4, "lockout");

    // Lockout exit: one cycle low returns to idle, a new rise restarts the budget.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "lockout_exit_idle");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, "fresh_start");

    // Mid-beep clear in the 2nd cycle of beep 2.
    for (int i = 1; i < 7; i++) ev_step(i, "pre_clear");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "mid_beep_clear");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "clear_silent");

    // Mid-operation reset during the off phase of beep 3.
    for (int i = 0; i < 14; i++) ev_step(i, "pre_reset");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "mid_reset");
    for (int i = 0; i < 18; i++) ev_step(i, "after_reset");

    // Clear on the last on-cycle of the final beep wins over lockout entry.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "clear_beats_lockout");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "idle_after_clear");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "park_a");

    // Minimum-parameter instance: a single one-cycle beep, then lockout.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "edge_reset");
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "edge_reset");
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, "edge_beep");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, "edge_lockout");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "edge_exit");
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, "edge_rebeep");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "edge_clear");

    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
